// File: rtl/post_cov_semipar_core_pkg.sv
// Shared fixed-point types and helpers for the KF datapath blocks.
// Word format, saturation helper and the posterior-covariance FSM encoding.
package fxp_types;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;

    // Clamp a wide signed value to the n-bit two's complement range.
    function automatic logic signed [63:0] fxp_sat(
        input logic signed [63:0] v,
        input int                 n
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        KH_M0,
        KH_S0,
        KH_S1,
        PP_M0,
        PP_S0,
        PP_S1,
        OUT
    } pc_state_t;

endpackage

// File: rtl/post_cov_semipar_core_dot2.sv
// Registered 2-term fixed-point dot product: products in one cycle,
// sum / arithmetic shift / saturate in the next.
module fxp_dot2
    import fxp_types::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] x0,
    input  logic signed [N-1:0] y0,
    input  logic signed [N-1:0] x1,
    input  logic signed [N-1:0] y1,
    output logic signed [N-1:0] q
);

    logic signed [2*N-1:0] pr0;
    logic signed [2*N-1:0] pr1;
    logic signed [2*N:0]   sum;
    logic signed [2*N:0]   sh;
    logic signed [63:0]    wide;
    logic signed [63:0]    clamped;

    always_comb begin
        sum     = (2*N+1)'(pr0) + (2*N+1)'(pr1);
        sh      = sum >>> FRAC;
        wide    = 64'(sh);
        clamped = fxp_sat(wide, N);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr0 <= '0;
            pr1 <= '0;
            q   <= '0;
        end else begin
            pr0 <= (2*N)'(x0) * (2*N)'(y0);
            pr1 <= (2*N)'(x1) * (2*N)'(y1);
            q   <= clamped[N-1:0];
        end
    end

endmodule

// File: rtl/post_cov_semipar_core.sv
// Posterior covariance P_post = (I - K*H) * P_prior for a 2x2 state,
// two time-shared dot-product units over a fixed 7-cycle schedule.
module post_cov_semipar_core
    import fxp_types::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] k00,
    input  logic signed [N-1:0] k01,
    input  logic signed [N-1:0] k10,
    input  logic signed [N-1:0] k11,
    input  logic signed [N-1:0] h00,
    input  logic signed [N-1:0] h01,
    input  logic signed [N-1:0] h10,
    input  logic signed [N-1:0] h11,
    input  logic signed [N-1:0] p_prior00,
    input  logic signed [N-1:0] p_prior01,
    input  logic signed [N-1:0] p_prior10,
    input  logic signed [N-1:0] p_prior11,
    output logic                done,
    output logic signed [N-1:0] P_post00,
    output logic signed [N-1:0] P_post01,
    output logic signed [N-1:0] P_post10,
    output logic signed [N-1:0] P_post11
);

    localparam logic signed [N:0] ONE = (N+1)'(2 ** FRAC);
    localparam logic signed [N:0] ZERO = '0;

    pc_state_t state;

    logic signed [N-1:0] kr00, kr01, kr10, kr11;
    logic signed [N-1:0] hr00, hr01, hr10, hr11;
    logic signed [N-1:0] pr00, pr01, pr10, pr11;
    logic signed [N-1:0] a00, a01, a10, a11;
    logic signed [N-1:0] pt00, pt01;

    logic signed [N-1:0] u0x0, u0y0, u0x1, u0y1;
    logic signed [N-1:0] u1x0, u1y0, u1x1, u1y1;
    logic signed [N-1:0] q0, q1;
    logic signed [N-1:0] ad0, ao0, ad1, ao1;

    function automatic logic signed [N-1:0] sub_sat(
        input logic signed [N:0]   s,
        input logic signed [N-1:0] v
    );
        logic signed [N:0]  d;
        logic signed [63:0] c;
        d = s - (N+1)'(v);
        c = fxp_sat(64'(d), N);
        return c[N-1:0];
    endfunction

    // Unit 0 always produces column 0, unit 1 column 1 of the current row.
    always_comb begin
        u0x0 = '0; u0y0 = '0; u0x1 = '0; u0y1 = '0;
        u1x0 = '0; u1y0 = '0; u1x1 = '0; u1y1 = '0;
        unique case (state)
            KH_M0: begin
                u0x0 = kr00; u0y0 = hr00; u0x1 = kr01; u0y1 = hr10;
                u1x0 = kr00; u1y0 = hr01; u1x1 = kr01; u1y1 = hr11;
            end
            KH_S0: begin
                u0x0 = kr10; u0y0 = hr00; u0x1 = kr11; u0y1 = hr10;
                u1x0 = kr10; u1y0 = hr01; u1x1 = kr11; u1y1 = hr11;
            end
            PP_M0: begin
                u0x0 = a00; u0y0 = pr00; u0x1 = a01; u0y1 = pr10;
                u1x0 = a00; u1y0 = pr01; u1x1 = a01; u1y1 = pr11;
            end
            PP_S0: begin
                u0x0 = a10; u0y0 = pr00; u0x1 = a11; u0y1 = pr10;
                u1x0 = a10; u1y0 = pr01; u1x1 = a11; u1y1 = pr11;
            end
            default: ;
        endcase
    end

    always_comb begin
        ad0 = sub_sat(ONE, q0);
        ao0 = sub_sat(ZERO, q0);
        ad1 = sub_sat(ONE, q1);
        ao1 = sub_sat(ZERO, q1);
    end

    fxp_dot2 #(.N(N), .FRAC(FRAC)) u_dot0 (
        .clk (clk),
        .rst (rst),
        .x0  (u0x0),
        .y0  (u0y0),
        .x1  (u0x1),
        .y1  (u0y1),
        .q   (q0)
    );

    fxp_dot2 #(.N(N), .FRAC(FRAC)) u_dot1 (
        .clk (clk),
        .rst (rst),
        .x0  (u1x0),
        .y0  (u1y0),
        .x1  (u1x1),
        .y1  (u1y1),
        .q   (q1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            kr00 <= '0; kr01 <= '0; kr10 <= '0; kr11 <= '0;
            hr00 <= '0; hr01 <= '0; hr10 <= '0; hr11 <= '0;
            pr00 <= '0; pr01 <= '0; pr10 <= '0; pr11 <= '0;
            a00  <= '0; a01  <= '0; a10  <= '0; a11  <= '0;
            pt00 <= '0; pt01 <= '0;
            P_post00 <= '0; P_post01 <= '0;
            P_post10 <= '0; P_post11 <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        kr00 <= k00; kr01 <= k01; kr10 <= k10; kr11 <= k11;
                        hr00 <= h00; hr01 <= h01; hr10 <= h10; hr11 <= h11;
                        pr00 <= p_prior00; pr01 <= p_prior01;
                        pr10 <= p_prior10; pr11 <= p_prior11;
                        state <= KH_M0;
                    end
                end
                KH_M0: state <= KH_S0;
                KH_S0: state <= KH_S1;
                KH_S1: begin
                    a00   <= ad0;
                    a01   <= ao1;
                    state <= PP_M0;
                end
                PP_M0: begin
                    a10   <= ao0;
                    a11   <= ad1;
                    state <= PP_S0;
                end
                PP_S0: state <= PP_S1;
                PP_S1: begin
                    pt00  <= q0;
                    pt01  <= q1;
                    state <= OUT;
                end
                OUT: begin
                    P_post00 <= pt00;
                    P_post01 <= pt01;
                    P_post10 <= q0;
                    P_post11 <= q1;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_post_cov_semipar_core.sv
// Directed bench for post_cov_semipar_core with a scoreboard of
// reference results computed in 64-bit integer arithmetic.
module tb_post_cov_semipar_core;
    import fxp_types::*;

    localparam int N    = FXP_N;
    localparam int FRAC = FXP_FRAC;
    localparam int S    = 1 << FRAC;
    localparam int MAXV = (1 << (N - 1)) - 1;

    typedef struct packed {
        logic signed [N-1:0] m00;
        logic signed [N-1:0] m01;
        logic signed [N-1:0] m10;
        logic signed [N-1:0] m11;
    } mat_t;

    logic clk;
    logic rst;
    logic start;
    logic signed [N-1:0] k00, k01, k10, k11;
    logic signed [N-1:0] h00, h01, h10, h11;
    logic signed [N-1:0] p00, p01, p10, p11;
    logic done;
    logic signed [N-1:0] o00, o01, o10, o11;

    mat_t exp_q[$];
    int tests = 0;
    int fails = 0;

    post_cov_semipar_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k00       (k00),
        .k01       (k01),
        .k10       (k10),
        .k11       (k11),
        .h00       (h00),
        .h01       (h01),
        .h10       (h10),
        .h11       (h11),
        .p_prior00 (p00),
        .p_prior01 (p01),
        .p_prior10 (p10),
        .p_prior11 (p11),
        .done      (done),
        .P_post00  (o00),
        .P_post01  (o01),
        .P_post10  (o10),
        .P_post11  (o11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic longint sat(input longint v);
        longint lo;
        longint hi;
        hi = (64'sd1 <<< (N - 1)) - 1;
        lo = -(64'sd1 <<< (N - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic mat_t mk(input int a, input int b, input int c, input int d);
        mat_t m;
        m.m00 = N'(a);
        m.m01 = N'(b);
        m.m10 = N'(c);
        m.m11 = N'(d);
        return m;
    endfunction

    function automatic mat_t model(input mat_t k, input mat_t h, input mat_t p);
        longint km[2][2];
        longint hm[2][2];
        longint pm[2][2];
        longint am[2][2];
        longint rm[2][2];
        mat_t r;
        km[0][0] = longint'(signed'(k.m00)); km[0][1] = longint'(signed'(k.m01));
        km[1][0] = longint'(signed'(k.m10)); km[1][1] = longint'(signed'(k.m11));
        hm[0][0] = longint'(signed'(h.m00)); hm[0][1] = longint'(signed'(h.m01));
        hm[1][0] = longint'(signed'(h.m10)); hm[1][1] = longint'(signed'(h.m11));
        pm[0][0] = longint'(signed'(p.m00)); pm[0][1] = longint'(signed'(p.m01));
        pm[1][0] = longint'(signed'(p.m10)); pm[1][1] = longint'(signed'(p.m11));
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                longint kh;
                kh = sat((km[i][0] * hm[0][j] + km[i][1] * hm[1][j]) >>> FRAC);
                am[i][j] = sat(((i == j) ? longint'(S) : 0) - kh);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                rm[i][j] = sat((am[i][0] * pm[0][j] + am[i][1] * pm[1][j]) >>> FRAC);
        r.m00 = N'(rm[0][0]);
        r.m01 = N'(rm[0][1]);
        r.m10 = N'(rm[1][0]);
        r.m11 = N'(rm[1][1]);
        return r;
    endfunction

    task automatic drive(input mat_t k, input mat_t h, input mat_t p);
        k00 = k.m00; k01 = k.m01; k10 = k.m10; k11 = k.m11;
        h00 = h.m00; h01 = h.m01; h10 = h.m10; h11 = h.m11;
        p00 = p.m00; p01 = p.m01; p10 = p.m10; p11 = p.m11;
    endtask

    // Drives start for one edge (E1); returns 1 time unit after E1.
    task automatic launch(input mat_t k, input mat_t h, input mat_t p, input bit push);
        drive(k, h, p);
        start = 1'b1;
        if (push) exp_q.push_back(model(k, h, p));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // cnt0 is the edge index already passed (1 = just after E1).
    task automatic wait_done(input string tag, input int cnt0, input bit fall);
        int cnt;
        bit seen;
        mat_t e;
        cnt = cnt0;
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, seen ? cnt : -1, 8);
        if (seen) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_p00"}, o00, signed'(e.m00));
                chk({tag, "_p01"}, o01, signed'(e.m01));
                chk({tag, "_p10"}, o10, signed'(e.m10));
                chk({tag, "_p11"}, o11, signed'(e.m11));
            end
        end
        if (fall) begin
            @(posedge clk);
            #1 chk({tag, "_done_fall"}, done, 0);
        end
    endtask

    initial begin : stim
        mat_t hi;
        mat_t kh;
        mat_t ki;
        mat_t pi;
        mat_t ks;
        int quiet;

        hi = mk(S, 0, 0, S);
        kh = mk(S / 2, 0, 0, S / 2);
        ki = mk(S, 0, 0, S);
        pi = mk(S, 0, 0, S);
        ks = mk(MAXV, 0, 0, MAXV);

        rst = 1'b1;
        start = 1'b0;
        drive(mk(0, 0, 0, 0), mk(0, 0, 0, 0), mk(0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_p00", o00, 0);
        chk("rst_p01", o01, 0);
        chk("rst_p10", o10, 0);
        chk("rst_p11", o11, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        launch(kh, hi, pi, 1'b1);
        wait_done("half_i", 1, 1'b1);
        chk("half_i_diag", o00, S / 2);

        launch(mk(S / 2, S / 4, 0, S / 2), hi, pi, 1'b1);
        wait_done("upper", 1, 1'b1);
        chk("upper_p01", o01, -(S / 4));

        launch(ks, ks, pi, 1'b1);
        wait_done("sat", 1, 1'b1);
        chk("sat_p11", o11, S - MAXV);

        launch(ki, hi, mk(-3, 0, 0, 0), 1'b1);
        wait_done("trunc0", 1, 1'b1);
        chk("trunc0_p00", o00, 0);

        launch(kh, hi, mk(-3, 0, 0, 0), 1'b1);
        wait_done("trunc_neg", 1, 1'b1);
        chk("trunc_neg_p00", o00, -2);

        for (int r = 0; r < 4; r++) begin
            mat_t rk;
            mat_t rh;
            mat_t rp;
            rk = mk($urandom, $urandom, $urandom, $urandom);
            rh = mk($urandom, $urandom, $urandom, $urandom);
            rp = mk($urandom, $urandom, $urandom, $urandom);
            launch(rk, rh, rp, 1'b1);
            wait_done("rand", 1, 1'b1);
        end

        // Stray start at E3 must be ignored; then a start at E9 is accepted.
        launch(mk(S / 2, S / 4, -S / 8, S), mk(S, S / 2, 0, S), mk(S, 7, -5, 2 * S), 1'b1);
        @(posedge clk);
        #1;
        drive(ks, ks, mk(-100, 3, 3, 9));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy", 3, 1'b0);
        launch(kh, mk(S, -S, S / 2, S), mk(S, S, -S, S), 1'b1);
        chk("busy_done_fall", done, 0);
        wait_done("e9", 1, 1'b1);

        // Reset mid-run discards the computation and clears outputs.
        launch(ks, hi, pi, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_done", done, 0);
        chk("mid_rst_p00", o00, 0);
        chk("mid_rst_p11", o11, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (done) quiet++;
        end
        chk("mid_rst_no_done", quiet, 0);
        chk("mid_rst_p01", o01, 0);
        chk("mid_rst_p10", o10, 0);

        launch(mk(S / 2, S / 4, 0, S / 2), hi, pi, 1'b1);
        wait_done("after_rst", 1, 1'b1);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
